io_arbiter: RTL and testbench
=============================

IO_ARBITER -- requirements
Module: io_arbiter

Interface
REQ-001 Parameter AW, default 8: IO memory address width.
REQ-002 Parameter DW, default 24: IO memory data width.
REQ-003 Parameter WR_LIMIT, default 35: highest writable IO address (output bit field).
REQ-004 Parameter RD_LIMIT, default 75: highest readable IO address (switches/gpio/output field).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 req[1:0]  input  2  per-requester access request; requester 0 = core, 1 = auxiliary.
REQ-008 we[1:0]  input  2  per-requester write flag (1 = write, 0 = read).
REQ-009 addr0, addr1  input  AW each  per-requester IO address.
REQ-010 wdata0, wdata1  input  DW each  per-requester write data; only bit 0 is meaningful to memory.
REQ-011 gnt[1:0]  output  2  one-cycle grant pulse, one-hot or zero.
REQ-012 rvalid[1:0]  output  2  one-cycle completion pulse to the served requester.
REQ-013 rdata  output  DW  read data for the completing transaction, shared by both requesters.
REQ-014 err  output  1  out-of-range flag, valid with rvalid.
REQ-015 mem_en  output  1  write enable to IO memory.
REQ-016 mem_address  output  AW  address to IO memory.
REQ-017 mem_dataIn  output  DW  write data to IO memory.
REQ-018 mem_dataOut  input  DW  combinational read data from IO memory.

Function
REQ-019 FSM states IDLE, ACCESS, RESP; IDLE->ACCESS when any req sampled high; ACCESS->RESP unconditionally; RESP->IDLE unconditionally.
REQ-020 In IDLE with req!=0, the winner's we/addr/wdata and identity are latched into registers at the clock edge.
REQ-021 Arbitration: round-robin with a last-served pointer; sole requester always wins; on contention the requester not last served wins; pointer is 1 after reset, so requester 0 wins the first contention.
REQ-022 gnt[winner] is high for exactly the ACCESS cycle; requester holds req until it sees gnt and may deassert from the cycle after gnt.
REQ-023 A req dropped before it is sampled in IDLE produces no transaction.
REQ-024 During ACCESS, mem_address and mem_dataIn come from the latched registers; otherwise both are 0.
REQ-025 mem_en is high only in ACCESS, only for a write with latched address <= WR_LIMIT.
REQ-026 Read: mem_dataOut is captured into rdata at the ACCESS->RESP edge when latched address <= RD_LIMIT; otherwise rdata is loaded with 0.
REQ-027 Write: rdata is loaded with 0.
REQ-028 In RESP, rvalid[served] is high for one cycle, rdata is stable, and err = 1 iff (write and address > WR_LIMIT) or (read and address > RD_LIMIT).
REQ-029 Address comparisons are unsigned at AW width; address 255 is out of range for both reads and writes.
REQ-030 A transaction occupies exactly 3 cycles (IDLE sample, ACCESS, RESP); peak throughput is one transaction per 3 cycles.
REQ-031 Requests arriving during ACCESS/RESP wait; they are re-arbitrated in the next IDLE cycle.
REQ-032 rdata holds its value outside RESP until the next transaction loads it.

Reset
REQ-033 rst forces state IDLE, pointer 1, latched registers 0, gnt 0, rvalid 0, err 0, rdata 0, mem_en 0, mem_address 0, mem_dataIn 0.
REQ-034 A reset asserted mid-transaction aborts it with no rvalid and no memory write after reset assertion.

Structure
REQ-035 A shared package io_pkg holds the state enum (IDLE/ACCESS/RESP) and the AW, DW, WR_LIMIT and RD_LIMIT defaults.
REQ-036 The two-way round-robin pick is a sub-module, rr_arbiter2 (inputs req[1:0] and last pointer; output one-hot winner).

Verification
REQ-037 Scenario: single write, req0=1, we0=1, addr0=5, wdata0=1 -> gnt0 in cycle 1, mem_en=1 and mem_address=5 in cycle 1, rvalid0 in cycle 2 with err=0.
REQ-038 Scenario: read, req1=1, addr1=40, mem_dataOut=1 during ACCESS -> rvalid1 with rdata=1 and err=0.
REQ-039 Scenario: contention, req=2'b11 held continuously -> grants alternate gnt0, gnt1, gnt0, with 3 cycles between successive grants.
REQ-040 Scenario: out of range, write to addr 36 and read of addr 76 -> mem_en stays 0, rdata=0, err=1 with each rvalid.
REQ-041 Scenario: rst pulsed during ACCESS of a write -> all outputs 0 immediately, no rvalid, FSM re-arbitrates in IDLE after release.
REQ-042 Scenario: req0 pulsed for one cycle while a req1 transaction is in RESP -> no grant to requester 0 and no rvalid0.

Source files
------------

// File: rtl/io_pkg.sv
// io_pkg: shared types and parameter defaults for the IO arbiter.
//   state_t      : arbiter FSM states (IDLE, ACCESS, RESP)
//   *_DEF        : defaults for address/data width and the writable/readable
//                  address limits of the IO memory map
package io_pkg;

   localparam int AW_DEF       = 8;
   localparam int DW_DEF       = 24;
   localparam int WR_LIMIT_DEF = 35;
   localparam int RD_LIMIT_DEF = 75;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

endpackage

// File: rtl/io_arbiter_if.sv
// io_arbiter_if: requester handshake plus IO memory port of the arbiter.
//   Requester side : req, we, addr0/1, wdata0/1 -> gnt, rvalid, rdata, err
//   Memory side    : mem_en, mem_address, mem_dataIn -> mem_dataOut
//   modport slave  : the arbiter
//   modport master : the environment (requesters and IO memory)
// AW/DW must match the parameters of the io_arbiter instance using it.
interface io_arbiter_if
   import io_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
) ();

   logic [1:0]    req;
   logic [1:0]    we;
   logic [AW-1:0] addr0;
   logic [AW-1:0] addr1;
   logic [DW-1:0] wdata0;
   logic [DW-1:0] wdata1;
   logic [1:0]    gnt;
   logic [1:0]    rvalid;
   logic [DW-1:0] rdata;
   logic          err;
   logic          mem_en;
   logic [AW-1:0] mem_address;
   logic [DW-1:0] mem_dataIn;
   logic [DW-1:0] mem_dataOut;

   modport slave (
      input  req, we, addr0, addr1, wdata0, wdata1, mem_dataOut,
      output gnt, rvalid, rdata, err, mem_en, mem_address, mem_dataIn
   );

   modport master (
      output req, we, addr0, addr1, wdata0, wdata1, mem_dataOut,
      input  gnt, rvalid, rdata, err, mem_en, mem_address, mem_dataIn
   );

endinterface

// File: rtl/io_arbiter_rr.sv
// rr_arbiter2: two-way round-robin pick.
//   req[1:0] : active requests
//   last     : index of the requester served most recently
//   win[1:0] : one-hot winner, zero when nobody requests
// A sole requester always wins; on contention the one not served last wins.
module rr_arbiter2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] win
);

   always_comb begin
      win = 2'b00;
      case (req)
         2'b01:   win = 2'b01;
         2'b10:   win = 2'b10;
         2'b11:   win = last ? 2'b01 : 2'b10;
         default: win = 2'b00;
      endcase
   end

endmodule

// File: rtl/io_arbiter.sv
// io_arbiter: serialises IO memory accesses from two requesters (0 = core,
// 1 = auxiliary). Each transaction takes three cycles: sample in IDLE,
// memory access in ACCESS (gnt pulse), completion in RESP (rvalid pulse).
//   clk, rst : clock, asynchronous active-high reset
//   bus      : io_arbiter_if.slave, requester handshake and IO memory port
//
// state  | meaning
// IDLE   | waiting; winner's request latched on the edge when any req is high
// ACCESS | gnt to winner, memory driven from latched request, read captured
// RESP   | rvalid to winner with rdata/err
module io_arbiter
   import io_pkg::*;
#(
   parameter int AW       = AW_DEF,
   parameter int DW       = DW_DEF,
   parameter int WR_LIMIT = WR_LIMIT_DEF,
   parameter int RD_LIMIT = RD_LIMIT_DEF
) (
   input logic         clk,
   input logic         rst,
   io_arbiter_if.slave bus
);

   localparam logic [AW-1:0] WR_LIM = AW'(WR_LIMIT);
   localparam logic [AW-1:0] RD_LIM = AW'(RD_LIMIT);

   state_t        state;
   state_t        state_nxt;
   logic          last;
   logic [1:0]    win;
   logic          sel;
   logic          lat_we;
   logic          lat_id;
   logic [AW-1:0] lat_addr;
   logic [DW-1:0] lat_wdata;
   logic [DW-1:0] rdata_q;
   logic          wr_oor;
   logic          rd_oor;

   rr_arbiter2 u_rr (
      .req  (bus.req),
      .last (last),
      .win  (win)
   );

   assign sel    = (win == 2'b10);
   assign wr_oor = (lat_addr > WR_LIM);
   assign rd_oor = (lat_addr > RD_LIM);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt       = state;
      bus.gnt         = 2'b00;
      bus.rvalid      = 2'b00;
      bus.err         = 1'b0;
      bus.mem_en      = 1'b0;
      bus.mem_address = '0;
      bus.mem_dataIn  = '0;
      case (state)
         IDLE: begin
            if (win != 2'b00) state_nxt = ACCESS;
         end
         ACCESS: begin
            state_nxt       = RESP;
            bus.gnt         = lat_id ? 2'b10 : 2'b01;
            bus.mem_en      = lat_we && !wr_oor;
            bus.mem_address = lat_addr;
            bus.mem_dataIn  = lat_wdata;
         end
         RESP: begin
            state_nxt  = IDLE;
            bus.rvalid = lat_id ? 2'b10 : 2'b01;
            bus.err    = lat_we ? wr_oor : rd_oor;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // The pointer moves at the sampling edge, so a loser still holding req
   // wins the next IDLE cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last      <= 1'b1;
         lat_we    <= 1'b0;
         lat_id    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         rdata_q   <= '0;
      end else begin
         if (state == IDLE && win != 2'b00) begin
            last      <= sel;
            lat_id    <= sel;
            lat_we    <= sel ? bus.we[1] : bus.we[0];
            lat_addr  <= sel ? bus.addr1 : bus.addr0;
            lat_wdata <= sel ? bus.wdata1 : bus.wdata0;
         end
         if (state == ACCESS) begin
            rdata_q <= (!lat_we && !rd_oor) ? bus.mem_dataOut : '0;
         end
      end
   end

   assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_io_arbiter.sv
module tb_io_arbiter;
   import io_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   io_arbiter_if #(.AW(8), .DW(24)) bus ();

   io_arbiter #(.AW(8), .DW(24), .WR_LIMIT(35), .RD_LIMIT(75)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   // IO memory: one meaningful bit per address.
   logic env_mem [256];
   bit   init_done = 1'b0;
   bit   model_mem [256];
   int   model_last;

   function automatic logic init_bit(input int a);
      return a[3];
   endfunction

   assign bus.mem_dataOut = {23'd0, env_mem[bus.mem_address]};

   always @(posedge clk) begin
      if (!init_done) begin
         for (int i = 0; i < 256; i++) env_mem[i] <= init_bit(i);
         init_done <= 1'b1;
      end else if (bus.mem_en) begin
         env_mem[bus.mem_address] <= bus.mem_dataIn[0];
      end
   end

   task automatic idle_inputs();
      bus.req = 2'b00; bus.we = 2'b00;
      bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_last = 1;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({bus.gnt, bus.rvalid, bus.err, bus.mem_en} !== 6'd0) begin
         errors++;
         $display("FAIL reset_ctrl got gnt=%b rvalid=%b err=%b mem_en=%b want 0",
                  bus.gnt, bus.rvalid, bus.err, bus.mem_en);
      end
      checks++;
      if (bus.rdata !== 24'd0 || bus.mem_address !== 8'd0 || bus.mem_dataIn !== 24'd0) begin
         errors++;
         $display("FAIL reset_data got rdata=%h addr=%h din=%h want 0",
                  bus.rdata, bus.mem_address, bus.mem_dataIn);
      end
      rst = 1'b0;
      model_last = 1;
   endtask

   task automatic test_single_write();
      do_reset();
      bus.req = 2'b01; bus.we = 2'b01; bus.addr0 = 8'd5; bus.wdata0 = 24'd1;
      @(posedge clk); #1;
      bus.req = 2'b00;
      checks++;
      if (bus.gnt !== 2'b01 || bus.mem_en !== 1'b1 || bus.mem_address !== 8'd5 || bus.mem_dataIn !== 24'd1) begin
         errors++;
         $display("FAIL wr_access got gnt=%b en=%b addr=%0d din=%h want 01 1 5 1",
                  bus.gnt, bus.mem_en, bus.mem_address, bus.mem_dataIn);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.rvalid !== 2'b01 || bus.err !== 1'b0 || bus.rdata !== 24'd0 || bus.gnt !== 2'b00) begin
         errors++;
         $display("FAIL wr_resp got rvalid=%b err=%b rdata=%h gnt=%b want 01 0 0 00",
                  bus.rvalid, bus.err, bus.rdata, bus.gnt);
      end
      model_mem[5] = 1'b1;
      checks++;
      if (env_mem[5] !== 1'b1) begin
         errors++;
         $display("FAIL wr_memory got %b want 1", env_mem[5]);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_read();
      do_reset();
      bus.req = 2'b10; bus.we = 2'b00; bus.addr1 = 8'd40;
      @(posedge clk); #1;
      bus.req = 2'b00;
      checks++;
      if (bus.gnt !== 2'b10 || bus.mem_en !== 1'b0 || bus.mem_address !== 8'd40) begin
         errors++;
         $display("FAIL rd_access got gnt=%b en=%b addr=%0d want 10 0 40",
                  bus.gnt, bus.mem_en, bus.mem_address);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.rvalid !== 2'b10 || bus.rdata !== 24'd1 || bus.err !== 1'b0) begin
         errors++;
         $display("FAIL rd_resp got rvalid=%b rdata=%h err=%b want 10 1 0",
                  bus.rvalid, bus.rdata, bus.err);
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++;
      if (bus.rdata !== 24'd1 || bus.rvalid !== 2'b00) begin
         errors++;
         $display("FAIL rd_hold got rdata=%h rvalid=%b want 1 00", bus.rdata, bus.rvalid);
      end
   endtask

   task automatic test_contention();
      int times[$];
      logic [1:0] grants[$];
      do_reset();
      bus.req = 2'b11; bus.we = 2'b00; bus.addr0 = 8'd1; bus.addr1 = 8'd2;
      for (int c = 1; c <= 15; c++) begin
         @(posedge clk); #1;
         if (bus.gnt !== 2'b00) begin
            times.push_back(c);
            grants.push_back(bus.gnt);
         end
      end
      bus.req = 2'b00;
      checks++;
      if (grants.size() < 3) begin
         errors++;
         $display("FAIL contention_count got %0d grants want at least 3", grants.size());
      end else begin
         checks++;
         if (grants[0] !== 2'b01 || grants[1] !== 2'b10 || grants[2] !== 2'b01) begin
            errors++;
            $display("FAIL contention_order got %b %b %b want 01 10 01",
                     grants[0], grants[1], grants[2]);
         end
         checks++;
         if (times[1] - times[0] != 3 || times[2] - times[1] != 3) begin
            errors++;
            $display("FAIL contention_spacing got %0d %0d want 3 3",
                     times[1] - times[0], times[2] - times[1]);
         end
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_out_of_range();
      do_reset();
      bus.req = 2'b01; bus.we = 2'b01; bus.addr0 = 8'd36; bus.wdata0 = 24'd1;
      @(posedge clk); #1;
      bus.req = 2'b00;
      checks++;
      if (bus.gnt !== 2'b01 || bus.mem_en !== 1'b0) begin
         errors++;
         $display("FAIL oor_wr_access got gnt=%b en=%b want 01 0", bus.gnt, bus.mem_en);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.rvalid !== 2'b01 || bus.err !== 1'b1 || bus.rdata !== 24'd0) begin
         errors++;
         $display("FAIL oor_wr_resp got rvalid=%b err=%b rdata=%h want 01 1 0",
                  bus.rvalid, bus.err, bus.rdata);
      end
      @(posedge clk); #1;
      bus.req = 2'b10; bus.we = 2'b00; bus.addr1 = 8'd76;
      @(posedge clk); #1;
      bus.req = 2'b00;
      @(posedge clk); #1;
      checks++;
      if (bus.rvalid !== 2'b10 || bus.err !== 1'b1 || bus.rdata !== 24'd0) begin
         errors++;
         $display("FAIL oor_rd_resp got rvalid=%b err=%b rdata=%h want 10 1 0",
                  bus.rvalid, bus.err, bus.rdata);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.req = 2'b01; bus.we = 2'b00; bus.addr0 = 8'd40;
      @(posedge clk); #1;
      bus.req = 2'b00;
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.req = 2'b01; bus.we = 2'b01; bus.addr0 = 8'd7; bus.wdata0 = 24'd1;
      @(posedge clk); #1;
      checks++;
      if (bus.gnt !== 2'b01 || bus.mem_en !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_access got gnt=%b en=%b want 01 1", bus.gnt, bus.mem_en);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({bus.gnt, bus.rvalid, bus.err, bus.mem_en} !== 6'd0 || bus.rdata !== 24'd0 ||
          bus.mem_address !== 8'd0 || bus.mem_dataIn !== 24'd0) begin
         errors++;
         $display("FAIL rstmid_outputs got gnt=%b rvalid=%b err=%b en=%b rdata=%h addr=%h want all 0",
                  bus.gnt, bus.rvalid, bus.err, bus.mem_en, bus.rdata, bus.mem_address);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      model_last = 1;
      checks++;
      if (bus.rvalid !== 2'b00 || env_mem[7] !== model_mem[7]) begin
         errors++;
         $display("FAIL rstmid_aborted got rvalid=%b mem7=%b want 00 %b",
                  bus.rvalid, env_mem[7], model_mem[7]);
      end
      @(posedge clk); #1;
      bus.req = 2'b00;
      checks++;
      if (bus.gnt !== 2'b01 || bus.mem_en !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_rearb got gnt=%b en=%b want 01 1", bus.gnt, bus.mem_en);
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
      model_mem[7] = 1'b1;
      checks++;
      if (env_mem[7] !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_write got mem7=%b want 1", env_mem[7]);
      end
   endtask

   task automatic test_pulse_during_resp();
      bit bad = 1'b0;
      do_reset();
      bus.req = 2'b10; bus.we = 2'b00; bus.addr1 = 8'd3;
      @(posedge clk); #1;
      bus.req = 2'b00;
      @(posedge clk); #1;
      bus.req = 2'b01; bus.we = 2'b00; bus.addr0 = 8'd9;
      if (bus.gnt[0] !== 1'b0 || bus.rvalid[0] !== 1'b0) bad = 1'b1;
      @(posedge clk); #1;
      bus.req = 2'b00;
      for (int c = 0; c < 5; c++) begin
         if (bus.gnt[0] !== 1'b0 || bus.rvalid[0] !== 1'b0) bad = 1'b1;
         @(posedge clk); #1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL pulse_ignored got a grant or rvalid to requester 0 want none");
      end
   endtask

   task automatic test_random(input int n);
      bit            pend  [2];
      bit            pwe   [2];
      logic [7:0]    paddr [2];
      logic [23:0]   pwd   [2];
      logic [7:0]    edge_addr [6];
      int            w;
      logic [1:0]    exp_oh;
      logic [23:0]   exp_rdata;
      logic          exp_err;
      logic          exp_en;
      edge_addr = '{8'd0, 8'd35, 8'd36, 8'd75, 8'd76, 8'd255};
      do_reset();
      pend[0] = 1'b0; pend[1] = 1'b0;
      for (int it = 0; it < n; it++) begin
         for (int r = 0; r < 2; r++) begin
            if (!pend[r] && $urandom_range(1, 0) == 1) begin
               pend[r]  = 1'b1;
               pwe[r]   = 1'($urandom_range(1, 0));
               paddr[r] = ($urandom_range(2, 0) == 0) ? edge_addr[$urandom_range(5, 0)]
                                                       : 8'($urandom_range(255, 0));
               pwd[r]   = 24'($urandom);
            end
         end
         if (!pend[0] && !pend[1]) begin
            w = int'($urandom_range(1, 0));
            pend[w] = 1'b1; pwe[w] = 1'($urandom_range(1, 0));
            paddr[w] = 8'($urandom_range(255, 0)); pwd[w] = 24'($urandom);
         end
         bus.req    = {pend[1], pend[0]};
         bus.we     = {pwe[1], pwe[0]};
         bus.addr0  = paddr[0]; bus.addr1  = paddr[1];
         bus.wdata0 = pwd[0];   bus.wdata1 = pwd[1];
         if (pend[0] && pend[1]) w = (model_last == 0) ? 1 : 0;
         else                    w = pend[1] ? 1 : 0;
         exp_oh = (w == 1) ? 2'b10 : 2'b01;
         exp_en = pwe[w] && (paddr[w] <= 8'd35);
         if (pwe[w]) begin
            exp_rdata = 24'd0;
            exp_err   = (paddr[w] > 8'd35);
         end else begin
            exp_rdata = (paddr[w] <= 8'd75) ? {23'd0, model_mem[paddr[w]]} : 24'd0;
            exp_err   = (paddr[w] > 8'd75);
         end
         @(posedge clk); #1;
         checks++;
         if (bus.gnt !== exp_oh || bus.mem_en !== exp_en || bus.mem_address !== paddr[w] ||
             bus.mem_dataIn !== pwd[w]) begin
            errors++;
            $display("FAIL rand_access it=%0d got gnt=%b en=%b addr=%0d din=%h want %b %b %0d %h",
                     it, bus.gnt, bus.mem_en, bus.mem_address, bus.mem_dataIn,
                     exp_oh, exp_en, paddr[w], pwd[w]);
         end
         if (exp_en) model_mem[paddr[w]] = pwd[w][0];
         model_last = w;
         pend[w] = 1'b0;
         bus.req[w] = 1'b0;
         @(posedge clk); #1;
         checks++;
         if (bus.rvalid !== exp_oh || bus.gnt !== 2'b00 || bus.rdata !== exp_rdata || bus.err !== exp_err) begin
            errors++;
            $display("FAIL rand_resp it=%0d got rvalid=%b gnt=%b rdata=%h err=%b want %b 00 %h %b",
                     it, bus.rvalid, bus.gnt, bus.rdata, bus.err, exp_oh, exp_rdata, exp_err);
         end
         @(posedge clk); #1;
         checks++;
         if (bus.rvalid !== 2'b00 || bus.rdata !== exp_rdata || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL rand_idle it=%0d got rvalid=%b rdata=%h err=%b want 00 %h 0",
                     it, bus.rvalid, bus.rdata, bus.err, exp_rdata);
         end
      end
      idle_inputs();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) model_mem[i] = init_bit(i);
      model_last = 1;
      idle_inputs();
      test_reset();
      test_single_write();
      test_read();
      test_contention();
      test_out_of_range();
      test_reset_mid();
      test_pulse_during_resp();
      test_random(60);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
